// File: rtl/nios_mem_if_ddr2_emif_0_p0_fifo_ctrl.sv
// FIFO controller for an external flop memory: pointer management, occupancy
// tracking, read-valid alignment and sticky overflow/underflow flags.
// The memory itself sits outside; this block only produces its enables and
// addresses. Read data from the memory is registered, so rd_valid_o lags the
// accepted pop by exactly one cycle.
module nios_mem_if_ddr2_emif_0_p0_fifo_ctrl #(
    parameter int DEPTH             = 8,
    parameter int ADDR_WIDTH        = 3,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  err_clr_i,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    output logic                  rd_valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_valid_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty;
    logic push_acc, pop_acc;

    // Flags come straight from the registered occupancy, so they never glitch
    // on push/pop and a push while full is dropped even if a pop is accepted.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push_acc = push_i & ~full;
    assign pop_acc  = pop_i & ~empty;

    // Next-state for pointers (wrap at DEPTH-1, depth need not be 2**n),
    // occupancy and sticky errors (a new error event beats err_clr).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        count_d = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (push_i && full) begin
            overflow_d = 1'b1;
        end else if (err_clr_i) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (pop_i && empty) begin
            underflow_d = 1'b1;
        end else if (err_clr_i) begin
            underflow_d = 1'b0;
        end
    end

    // State registers; reset discards all tracked contents immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign mem_wr_en_o   = push_acc;
    assign mem_wr_addr_o = wr_ptr_q;
    assign mem_rd_en_o   = pop_acc;
    assign mem_rd_addr_o = rd_ptr_q;
    assign rd_valid_o    = rd_valid_q;
    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= CNT_AF);
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: doc/nios_mem_if_ddr2_emif_0_p0_fifo_ctrl.md
NIOS_MEM_IF_DDR2_EMIF_0_P0_FIFO_CTRL -- requirements
Module: nios_mem_if_ddr2_emif_0_p0_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of entries in the attached flop memory (2..64; power of two not required).
REQ-002 Parameter ADDR_WIDTH, default 3, width of memory addresses; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-003 Parameter ALMOST_FULL_LEVEL, default 6, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  in  1  single clock; drives both write and read sides of the attached memory.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 push  in  1  request to store one entry this cycle.
REQ-007 pop  in  1  request to read one entry this cycle.
REQ-008 err_clr  in  1  clears sticky error flags.
REQ-009 mem_wr_en  out  1  write enable to memory.
REQ-010 mem_wr_addr  out  ADDR_WIDTH  write address to memory.
REQ-011 mem_rd_en  out  1  read enable to memory.
REQ-012 mem_rd_addr  out  ADDR_WIDTH  read address to memory.
REQ-013 rd_valid  out  1  memory read data valid this cycle.
REQ-014 count  out  ADDR_WIDTH+1  current occupancy.
REQ-015 full / empty / almost_full  out  1 each  occupancy flags.
REQ-016 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-017 pop_acc = pop AND NOT empty; push_acc = push AND NOT full; a push while full SHALL be dropped even if pop is accepted that cycle.
REQ-018 mem_wr_en SHALL equal push_acc combinationally; mem_wr_addr SHALL equal registered wr_ptr.
REQ-019 mem_rd_en SHALL equal pop_acc combinationally; mem_rd_addr SHALL equal registered rd_ptr.
REQ-020 wr_ptr SHALL advance by 1 on push_acc, wrapping DEPTH-1 -> 0; rd_ptr likewise on pop_acc.
REQ-021 rd_valid SHALL be a register loaded with pop_acc each cycle, giving exactly 1-cycle latency, aligned with the memory's registered read data.
REQ-022 count SHALL be registered: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither.
REQ-023 empty SHALL be (count == 0), full SHALL be (count == DEPTH), almost_full SHALL be (count >= ALMOST_FULL_LEVEL), all decoded from the registered count.
REQ-024 Simultaneous push_acc and pop_acc with equal pointers (count 0 impossible by REQ-017; count DEPTH excluded) SHALL not occur; with distinct pointers both proceed in the same cycle.
REQ-025 overflow SHALL set on the edge after push while full; underflow SHALL set on the edge after pop while empty; set SHALL take priority over err_clr in the same cycle.
REQ-026 err_clr without a simultaneous error event SHALL clear both flags on the next edge.
REQ-027 count SHALL never exceed DEPTH nor go below 0 under any input sequence.

Reset
REQ-028 While reset is high: wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0, mem_wr_en=0, mem_rd_en=0.
REQ-029 Reset assertion mid-operation SHALL take effect immediately without waiting for clk; stored memory contents are not tracked and SHALL be treated as discarded.
REQ-030 First accepted push after reset deassertion SHALL write address 0.

Verification (DEPTH=4, ADDR_WIDTH=2, ALMOST_FULL_LEVEL=3)
REQ-031 Reset, push 4 cycles -> mem_wr_addr 0,1,2,3; count 1..4; almost_full at count 3; full=1 after 4th; 5th push -> mem_wr_en=0, overflow=1 next edge.
REQ-032 From full, pop 4 cycles -> mem_rd_addr 0,1,2,3; rd_valid high cycles 2..5; empty=1 after 4th pop; extra pop -> mem_rd_en=0, underflow=1.
REQ-033 Count=2, push and pop together for 6 cycles -> count stays 2; both pointers wrap 3->0; rd_valid continuous one cycle behind.
REQ-034 Full, push and pop same cycle -> pop accepted, push dropped, count 3, overflow=1.
REQ-035 overflow=1, err_clr=1 with push while full in same cycle -> overflow stays 1; err_clr alone next cycle -> overflow=0.
REQ-036 Count=3, assert reset asynchronously between edges -> count=0, empty=1, rd_valid=0 immediately; next push writes address 0.
